// File: rtl/neuron_mac.sv
// neuron_mac: single-neuron multiply-accumulate engine.
// Accumulates syn_num signed Q8.8 weight*input products into a Q16.16
// accumulator, adds a Q8.8 bias, then saturates back to Q8.8 with an
// optional ReLU. One evaluation at a time, handshaked by start/out_vld.
module neuron_mac #(
   parameter int DATA_WIDTH = 16,
   parameter int ACC_WIDTH  = 40,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [CNT_WIDTH-1:0]  syn_num,
   input  logic [DATA_WIDTH-1:0] bias,
   input  logic                  act_en,
   input  logic                  df_rdy,
   input  logic [DATA_WIDTH-1:0] data_w,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic [DATA_WIDTH-1:0] neuron_out,
   output logic                  out_vld,
   output logic                  busy,
   output logic                  ovf
);

   localparam int PROD_WIDTH = 2 * DATA_WIDTH;
   // Lowest accumulator bit that must match the sign for the Q8.8 result to fit.
   localparam int SAT_LO     = DATA_WIDTH + 7;
   localparam int N_HI       = ACC_WIDTH - 1 - SAT_LO;

   typedef enum logic [1:0] {IDLE, ACC, BIAS, OUT} state_t;

   state_t                  state_reg;
   logic [ACC_WIDTH-1:0]    acc_reg;
   logic [CNT_WIDTH-1:0]    cnt_reg;
   logic [CNT_WIDTH-1:0]    syn_num_reg;
   logic [DATA_WIDTH-1:0]   bias_reg;
   logic                    act_en_reg;
   logic [DATA_WIDTH-1:0]   neuron_out_reg;
   logic                    out_vld_reg;
   logic                    ovf_reg;

   logic signed [PROD_WIDTH-1:0] prod;
   logic [ACC_WIDTH-1:0]    prod_ext;
   logic [ACC_WIDTH-1:0]    bias_ext;
   logic [N_HI-1:0]         sat_diff;
   logic                    clip;
   logic [DATA_WIDTH-1:0]   sat_val;
   logic [DATA_WIDTH-1:0]   result;

   // Full-precision signed product and Q8.8 -> Q16.16 bias alignment.
   assign prod     = $signed(data_w) * $signed(data_i);
   assign prod_ext = {{(ACC_WIDTH-PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};
   assign bias_ext = {{(ACC_WIDTH-DATA_WIDTH-8){bias_reg[DATA_WIDTH-1]}}, bias_reg, 8'h00};

   // Any upper accumulator bit differing from the sign bit means acc[ACC_WIDTH-1:8]
   // does not fit in DATA_WIDTH signed bits.
   genvar gi;
   generate
      for (gi = 0; gi < N_HI; gi++) begin : g_sat
         assign sat_diff[gi] = acc_reg[SAT_LO+gi] ^ acc_reg[ACC_WIDTH-1];
      end
   endgenerate

   assign clip = |sat_diff;

   // Saturate the truncated Q8.8 value, then apply ReLU when enabled.
   always_comb begin
      sat_val = acc_reg[SAT_LO:8];
      result  = '0;
      if (clip) begin
         sat_val = acc_reg[ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                        : {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end
      if (act_en_reg && sat_val[DATA_WIDTH-1]) begin
         result = '0;
      end else begin
         result = sat_val;
      end
   end

   // Evaluation sequencer: accept start, accumulate pairs, add bias, emit result.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg      <= IDLE;
         acc_reg        <= '0;
         cnt_reg        <= '0;
         syn_num_reg    <= '0;
         bias_reg       <= '0;
         act_en_reg     <= 1'b0;
         neuron_out_reg <= '0;
         out_vld_reg    <= 1'b0;
         ovf_reg        <= 1'b0;
      end else begin
         out_vld_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               // A start landing on the out_vld cycle is not taken.
               if (start && !out_vld_reg) begin
                  acc_reg     <= '0;
                  cnt_reg     <= '0;
                  syn_num_reg <= syn_num;
                  bias_reg    <= bias;
                  act_en_reg  <= act_en;
                  state_reg   <= (syn_num == '0) ? BIAS : ACC;
               end
            end
            ACC: begin
               if (df_rdy) begin
                  acc_reg <= acc_reg + prod_ext;
                  cnt_reg <= cnt_reg + CNT_WIDTH'(1);
                  if (cnt_reg == syn_num_reg - CNT_WIDTH'(1)) begin
                     state_reg <= BIAS;
                  end
               end
            end
            BIAS: begin
               acc_reg   <= acc_reg + bias_ext;
               state_reg <= OUT;
            end
            OUT: begin
               neuron_out_reg <= result;
               ovf_reg        <= clip;
               out_vld_reg    <= 1'b1;
               state_reg      <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign neuron_out = neuron_out_reg;
   assign out_vld    = out_vld_reg;
   assign ovf        = ovf_reg;
   assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_neuron_mac.sv
// Testbench for neuron_mac: directed vector table, randomized evaluations
// against an arithmetic reference model, and hand-written corner sequences.
module tb_neuron_mac;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  syn_num = '0;
   logic [15:0] bias = '0;
   logic        act_en = 1'b0;
   logic        df_rdy = 1'b0;
   logic [15:0] data_w = '0;
   logic [15:0] data_i = '0;
   logic [15:0] neuron_out;
   logic        out_vld;
   logic        busy;
   logic        ovf;

   int n_cmp = 0;
   int n_bad = 0;

   neuron_mac dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .syn_num    (syn_num),
      .bias       (bias),
      .act_en     (act_en),
      .df_rdy     (df_rdy),
      .data_w     (data_w),
      .data_i     (data_i),
      .neuron_out (neuron_out),
      .out_vld    (out_vld),
      .busy       (busy),
      .ovf        (ovf)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0]       syn;
      logic [15:0]      bias;
      logic             act;
      logic [7:0][15:0] w;
      logic [7:0][15:0] x;
      logic [7:0][3:0]  gap;
      logic [15:0]      exp_out;
      logic             exp_ovf;
   } vec_t;

   task automatic check(input string name, input longint act_v, input longint exp_v);
      n_cmp++;
      if (act_v != exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act_v, exp_v);
      end
   endtask

   function automatic vec_t mk3(input logic [7:0] syn, input logic [15:0] b, input logic act,
                                input logic [15:0] w0, input logic [15:0] x0, input logic [3:0] g0,
                                input logic [15:0] w1, input logic [15:0] x1, input logic [3:0] g1,
                                input logic [15:0] w2, input logic [15:0] x2, input logic [3:0] g2,
                                input logic [15:0] eo, input logic eov);
      vec_t v;
      v = '0;
      v.syn = syn; v.bias = b; v.act = act;
      v.w[0] = w0; v.x[0] = x0; v.gap[0] = g0;
      v.w[1] = w1; v.x[1] = x1; v.gap[1] = g1;
      v.w[2] = w2; v.x[2] = x2; v.gap[2] = g2;
      v.exp_out = eo; v.exp_ovf = eov;
      return v;
   endfunction

   // Reference: real-valued sum of products plus bias, floored to Q8.8,
   // clamped to the 16-bit signed range, then ReLU.
   function automatic void model(input vec_t v, output logic [15:0] o, output logic ov);
      longint acc;
      longint val;
      acc = 0;
      for (int k = 0; k < int'(v.syn); k++)
         acc += longint'($signed(v.w[k])) * longint'($signed(v.x[k]));
      acc += longint'($signed(v.bias)) * 256;
      val = acc >>> 8;
      ov = 1'b0;
      if (val > 32767) begin val = 32767; ov = 1'b1; end
      if (val < -32768) begin val = -32768; ov = 1'b1; end
      if (v.act && val < 0) val = 0;
      o = 16'(val);
   endfunction

   task automatic run(input vec_t v, input string name);
      int cyc;
      int busy_bad;
      @(negedge clk);
      syn_num = v.syn; bias = v.bias; act_en = v.act; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      syn_num = 8'($urandom); bias = 16'($urandom); act_en = 1'($urandom);
      busy_bad = busy ? 0 : 1;
      for (int k = 0; k < int'(v.syn); k++) begin
         for (int g = 0; g < int'(v.gap[k]); g++) begin
            df_rdy = 1'b0; data_w = 16'($urandom); data_i = 16'($urandom);
            @(negedge clk);
            if (!busy) busy_bad++;
         end
         df_rdy = 1'b1; data_w = v.w[k]; data_i = v.x[k];
         @(negedge clk);
         if (!busy) busy_bad++;
      end
      cyc = 0;
      while (!out_vld && cyc < 40) begin
         df_rdy = 1'($urandom); data_w = 16'($urandom); data_i = 16'($urandom);
         @(negedge clk);
         cyc++;
      end
      df_rdy = 1'b0;
      check({name, " latency"}, cyc, 2);
      check({name, " out"}, neuron_out, v.exp_out);
      check({name, " ovf"}, ovf, v.exp_ovf);
      check({name, " busy"}, busy_bad, 0);
      $display("txn %s: syn=%0d bias=%h act=%b out=%h ovf=%b lat=%0d", name, v.syn, v.bias,
               v.act, neuron_out, ovf, cyc);
      @(negedge clk);
      check({name, " pulse"}, out_vld, 0);
      check({name, " hold"}, neuron_out, v.exp_out);
   endtask

   vec_t tbl[7];
   vec_t rv;
   logic [15:0] eo;
   logic        eov;
   int          vld_seen;

   initial begin
      tbl[0] = mk3(3, 16'h0080, 0, 16'h0100, 16'h0200, 0, 16'h0080, 16'h0400, 0, 16'hFF00, 16'h0100, 0, 16'h0380, 0);
      tbl[1] = mk3(3, 16'h0080, 0, 16'h0100, 16'h0200, 1, 16'h0080, 16'h0400, 3, 16'hFF00, 16'h0100, 0, 16'h0380, 0);
      tbl[2] = mk3(1, 16'h0000, 0, 16'hFF00, 16'h0300, 0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 0, 16'hFD00, 0);
      tbl[3] = mk3(1, 16'h0000, 1, 16'hFF00, 16'h0300, 0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 0, 16'h0000, 0);
      tbl[4] = mk3(2, 16'h0000, 0, 16'h7F00, 16'h7F00, 0, 16'h7F00, 16'h7F00, 0, 16'h0, 16'h0, 0, 16'h7FFF, 1);
      tbl[5] = mk3(2, 16'h0000, 0, 16'h8100, 16'h7F00, 0, 16'h8100, 16'h7F00, 2, 16'h0, 16'h0, 0, 16'h8000, 1);
      tbl[6] = mk3(0, 16'h0240, 0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 0, 16'h0240, 0);

      // Power-on reset.
      #2 reset = 1'b0;
      #1;
      check("reset outputs", {neuron_out, out_vld, busy, ovf}, 0);
      @(negedge clk);
      reset = 1'b1;

      for (int t = 0; t < 7; t++) run(tbl[t], $sformatf("vec%0d", t));

      // Negative saturation followed by ReLU still reports the clip.
      run(mk3(2, 16'h0000, 1, 16'h8100, 16'h7F00, 0, 16'h8100, 16'h7F00, 0, 16'h0, 16'h0, 0, 16'h0000, 1), "sat_relu");

      // Randomized evaluations against the reference model.
      for (int r = 0; r < 25; r++) begin
         rv = '0;
         rv.syn = 8'($urandom_range(0, 8));
         rv.bias = 16'($urandom);
         rv.act = 1'($urandom);
         for (int k = 0; k < 8; k++) begin
            rv.w[k] = 16'($urandom);
            rv.x[k] = 16'($urandom);
            rv.gap[k] = 4'($urandom_range(0, 3));
         end
         model(rv, eo, eov);
         rv.exp_out = eo; rv.exp_ovf = eov;
         run(rv, $sformatf("rand%0d", r));
      end

      // Start pulsed during accumulation must not disturb the running evaluation.
      @(negedge clk);
      syn_num = 8'd2; bias = 16'h0000; act_en = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      df_rdy = 1'b1; data_w = 16'h0100; data_i = 16'h0100;
      @(negedge clk);
      df_rdy = 1'b0; syn_num = 8'd1; bias = 16'h7F00; act_en = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0; df_rdy = 1'b1; data_w = 16'h0200; data_i = 16'h0100;
      @(negedge clk);
      df_rdy = 1'b0;
      vld_seen = 0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         if (out_vld) vld_seen = c + 1;
      end
      check("start_in_acc vld", vld_seen, 2);
      check("start_in_acc out", neuron_out, 16'h0300);
      $display("txn start_in_acc: out=%h ovf=%b", neuron_out, ovf);

      // Start coinciding with out_vld is dropped.
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_on_vld busy", busy, 0);
      $display("txn start_on_vld: busy=%b", busy);

      // Leave ovf/neuron_out nonzero, then abort an evaluation with reset.
      run(tbl[4], "pre_reset");
      @(negedge clk);
      syn_num = 8'd3; bias = 16'h0080; act_en = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0; df_rdy = 1'b1; data_w = 16'h0100; data_i = 16'h0200;
      @(negedge clk);
      check("acc before reset busy", busy, 1);
      reset = 1'b0;
      #1;
      check("reset mid outputs", {neuron_out, out_vld, busy, ovf}, 0);
      @(negedge clk);
      reset = 1'b1;
      vld_seen = 0;
      for (int c = 0; c < 6; c++) begin
         df_rdy = 1'($urandom); data_w = 16'($urandom); data_i = 16'($urandom);
         @(negedge clk);
         if (out_vld || busy) vld_seen++;
      end
      df_rdy = 1'b0;
      check("post reset idle", vld_seen, 0);
      $display("txn reset_abort: out=%h vld=%b busy=%b ovf=%b", neuron_out, out_vld, busy, ovf);
      run(tbl[0], "after_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Global time bound so the bench always terminates.
   initial begin
      #500000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
